// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
package imem_loader_pkg;

   localparam int ADDR_W_DEF = 10;
   localparam int LEN_W      = 16;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LEN0  = 3'd1,
      S_LEN1  = 3'd2,
      S_LOAD  = 3'd3,
      S_WRITE = 3'd4,
      S_DONE  = 3'd5,
      S_ERR   = 3'd6
   } state_e;

endpackage

// File: rtl/loader_byte_packer.sv
// Packs little-endian stream bytes into 32-bit words; o_word_ready flags the
// accept of the fourth byte, with o_word already including that byte.
module loader_byte_packer (
   input  logic        clk,
   input  logic        r,
   input  logic        i_clear,
   input  logic        i_accept,
   input  logic [7:0]  i_byte,
   output logic [31:0] o_word,
   output logic        o_word_ready
);

   logic [1:0]  r_byte_idx;
   logic [23:0] r_shift;

   // Each new byte enters at the top, so the first byte ends up in [7:0].
   assign o_word       = {i_byte, r_shift};
   assign o_word_ready = i_accept && (r_byte_idx == 2'd3);

   // NOTE: sequential state is updated with non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (r || i_clear) begin
         r_byte_idx <= '0;
         r_shift    <= '0;
      end else if (i_accept) begin
         r_byte_idx <= r_byte_idx + 2'd1;
         r_shift    <= o_word[31:8];
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed byte frame, writes it to instruction
// memory word by word and keeps the CPU in reset until a full image has landed.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W        = ADDR_W_DEF,
   parameter int TIMEOUT       = 65535,
   parameter bit HOLD_AT_RESET = 1'b1
) (
   input  logic              clk,
   input  logic              r,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic [ADDR_W-1:0] i_mem_addr,
   output logic [31:0]       i_mem_data,
   output logic              i_mem_write,
   output logic              cpu_r,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam int DEPTH = 2 ** ADDR_W;

   state_e            r_state, w_next_state;
   logic [LEN_W-1:0]  r_len;
   logic [ADDR_W:0]   r_word_addr;
   logic [ADDR_W:0]   w_addr_inc;
   logic [CNT_W-1:0]  r_idle;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [31:0]       r_mem_data;
   logic              r_mem_write, r_cpu_r, r_busy, r_done, r_err;
   logic              w_mem_write, w_cpu_r, w_busy, w_done, w_err;
   logic              w_accept, w_timeout, w_len_bad, w_word_ready;
   logic [LEN_W-1:0]  w_len_full;
   logic [31:0]       w_word;

   assign in_ready   = (r_state == S_LEN0) || (r_state == S_LEN1) || (r_state == S_LOAD);
   assign w_accept   = in_valid && in_ready;
   assign w_timeout  = in_ready && !w_accept && (r_idle == CNT_W'(TIMEOUT - 1));
   assign w_len_full = {in_data, r_len[7:0]};
   assign w_len_bad  = (w_len_full == '0) || (32'(w_len_full) > 32'(DEPTH));
   // One extra address bit lets a DEPTH-word image terminate cleanly.
   assign w_addr_inc = r_word_addr + (ADDR_W + 1)'(1);

   loader_byte_packer u_packer (
      .clk          (clk),
      .r            (r),
      .i_clear      (r_state != S_LOAD),
      .i_accept     (w_accept && (r_state == S_LOAD)),
      .i_byte       (in_data),
      .o_word       (w_word),
      .o_word_ready (w_word_ready)
   );

   always_ff @(posedge clk) begin
      if (r) r_state <= S_IDLE;
      else   r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE, S_DONE, S_ERR: if (start) w_next_state = S_LEN0;
         S_LEN0:  if (w_accept)          w_next_state = S_LEN1;
                  else if (w_timeout)    w_next_state = S_ERR;
         S_LEN1:  if (w_accept)          w_next_state = w_len_bad ? S_ERR : S_LOAD;
                  else if (w_timeout)    w_next_state = S_ERR;
         S_LOAD:  if (w_word_ready)      w_next_state = S_WRITE;
                  else if (w_timeout)    w_next_state = S_ERR;
         S_WRITE: w_next_state = (32'(w_addr_inc) == 32'(r_len)) ? S_DONE : S_LOAD;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state and registered, so they line up
   // with the state they describe.
   always_comb begin
      // NOTE: every signal gets a default first so no latch is inferred.
      w_mem_write = 1'b0;
      w_cpu_r     = 1'b1;
      w_busy      = 1'b0;
      w_done      = 1'b0;
      w_err       = 1'b0;
      case (w_next_state)
         S_IDLE:                 w_cpu_r = HOLD_AT_RESET;
         S_LEN0, S_LEN1, S_LOAD: w_busy  = 1'b1;
         S_WRITE: begin
            w_busy      = 1'b1;
            w_mem_write = 1'b1;
         end
         S_DONE: begin
            w_done  = 1'b1;
            w_cpu_r = 1'b0;
         end
         S_ERR:   w_err   = 1'b1;
         default: w_cpu_r = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (r) begin
         r_len       <= '0;
         r_word_addr <= '0;
         r_idle      <= '0;
         r_mem_addr  <= '0;
         r_mem_data  <= '0;
         r_mem_write <= 1'b0;
         r_cpu_r     <= 1'b1;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_mem_write <= w_mem_write;
         r_cpu_r     <= w_cpu_r;
         r_busy      <= w_busy;
         r_done      <= w_done;
         r_err       <= w_err;

         if (w_accept || !in_ready) r_idle <= '0;
         else                       r_idle <= r_idle + CNT_W'(1);

         if (w_accept && (r_state == S_LEN0)) r_len <= LEN_W'(in_data);
         if (w_accept && (r_state == S_LEN1)) r_len <= w_len_full;

         if (r_state == S_LEN1)       r_word_addr <= '0;
         else if (r_state == S_WRITE) r_word_addr <= w_addr_inc;

         if (w_word_ready) begin
            r_mem_addr <= r_word_addr[ADDR_W-1:0];
            r_mem_data <= w_word;
         end
      end
   end

   assign i_mem_addr  = r_mem_addr;
   assign i_mem_data  = r_mem_data;
   assign i_mem_write = r_mem_write;
   assign cpu_r       = r_cpu_r;
   assign busy        = r_busy;
   assign done        = r_done;
   assign err         = r_err;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader for the pipelined RV32I core.
- Accepts a byte stream over a valid/ready handshake, packs little-endian bytes into 32-bit instruction words, and writes them sequentially into instruction memory.
- Holds the CPU in reset for the whole load and releases it only after a complete, well-formed image has been written.
- Sits beside the CPU top and drives the instruction-memory write port plus the CPU reset.

Parameters:
- ADDR_W, 10: instruction-memory word-address width. DEPTH = 2**ADDR_W words.
- TIMEOUT, 65535: maximum idle cycles between accepted bytes during a load before aborting.
- HOLD_AT_RESET, 1: if 1, cpu_r stays asserted after reset until the first successful load. If 0, the CPU is released on reset exit.

Ports:
- clk  in  1  system clock, rising-edge.
- r  in  1  reset, synchronous, active-high.
- start  in  1  single-cycle request to begin a load.
- in_valid  in  1  stream byte valid.
- in_data  in  8  stream byte.
- in_ready  out  1  loader can accept a byte.
- i_mem_addr  out  ADDR_W  instruction-memory word address.
- i_mem_data  out  32  instruction word to write.
- i_mem_write  out  1  instruction-memory write strobe.
- cpu_r  out  1  reset to CPU core.
- busy  out  1  load in progress.
- done  out  1  last load completed successfully (level).
- err  out  1  last load aborted (level).

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (r, sampled on posedge clk).
- Reset values:
  - state = IDLE; i_mem_write = 0; i_mem_addr = 0; i_mem_data = 0.
  - in_ready = 0; busy = 0; done = 0; err = 0.
  - cpu_r = 1 while r is high; afterwards cpu_r = HOLD_AT_RESET until the first DONE.
- Handshake: a byte transfers on a cycle with in_valid & in_ready. in_ready is high only in LEN0, LEN1 and LOAD.
- Frame format: 16-bit word count N (low byte first), then 4*N payload bytes. Each word is little-endian: first byte goes to [7:0], fourth to [31:24].
- States:
  - IDLE: on start, go to LEN0; busy=1; done/err cleared; cpu_r=1.
  - LEN0: accept the low count byte, go to LEN1.
  - LEN1: accept the high count byte. If N==0 or N>DEPTH, go to ERR. Otherwise go to LOAD with word_addr=0, byte_idx=0.
  - LOAD: accept payload bytes. byte_idx 0..3 wraps. On the 4th accepted byte, go to WRITE.
  - WRITE: one cycle, in_ready=0. i_mem_write=1 with i_mem_addr=word_addr and i_mem_data=assembled word. Then word_addr increments. If the new word_addr==N, go to DONE; else go to LOAD.
  - DONE: done=1, busy=0, cpu_r=0. start re-enters LEN0, which clears done and re-asserts cpu_r.
  - ERR: err=1, busy=0, cpu_r=1, in_ready=0. Only start (to LEN0) or r exits.
- Registered outputs: all outputs are registered except in_ready, which is decoded from state.
- Latency:
  - 4th byte of a word accepted in cycle k: i_mem_write high in cycle k+1.
  - Last word written in cycle k+1: done=1 and cpu_r=0 from cycle k+2.
- Timeout: the idle counter resets on every accepted byte and on entering LEN0. If it reaches TIMEOUT in LEN0, LEN1 or LOAD, go to ERR. It does not count in WRITE.
- i_mem_write is never high outside WRITE. Exactly N write strobes occur per successful load.
- start is ignored in LEN0, LEN1, LOAD and WRITE.
- r mid-load: return to IDLE immediately, with no further write strobe. Partially written memory is left as-is. cpu_r follows the reset rule above.
- Bytes presented while in_ready=0 are not consumed; the upstream source must hold them.
- Width rules: word_addr is ADDR_W+1 bits internally so N==DEPTH terminates correctly. i_mem_addr carries word_addr[ADDR_W-1:0].

Decomposition:
- Shared package: state encoding (IDLE, LEN0, LEN1, LOAD, WRITE, DONE, ERR), ADDR_W default, and the 16-bit frame-length field width.
- One sub-module: loader_byte_packer. It holds the 2-bit byte_idx, a 32-bit shift/assemble register and a word_ready pulse. Its inputs are clear, accept and the byte.

Test Plan:
- Normal load: start; N=2; bytes 13 00 00 00 93 00 10 00 → writes addr0=0x00000013 and addr1=0x00100093. done=1 and cpu_r=0 two cycles after the last byte. Exactly 2 strobes.
- Back-pressure: in_valid toggles 1/0 every cycle during a 1-word load → in_ready=0 in the WRITE cycle. No byte is lost or duplicated. The word is assembled correctly.
- Bad length: N=0 gives err=1, cpu_r=1, no strobe. N=1025 with ADDR_W=10 also gives err=1. N=1024 loads and last address=1023.
- Timeout: TIMEOUT=8; after 2 payload bytes, in_valid stays low for 8 cycles → err=1, in_ready=0. A following start with a valid frame recovers to done=1.
- Reset mid-load: assert r for one cycle after 6 payload bytes of N=3 → state IDLE, only 1 strobe seen, busy=0, cpu_r=1 (HOLD_AT_RESET=1).
- Ignored start: pulse start during LOAD → no restart. The load completes with the correct N writes.
